// File: rtl/dm_unloader.sv
// Data-memory drain engine: reads a [base, base+len) window from a 2-cycle BRAM and streams it out.
// First word 3 cycles after start; reads are credited against FIFO space so backpressure never drops data.
module dm_unloader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   raddr_cnt;
  logic [ADDR_WIDTH:0]     rd_left;
  logic [ADDR_WIDTH:0]     wr_left;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           in_flight;
  logic                    done_r;
  logic                    push;
  logic                    pop;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CW'(vld_sr[i]);
    end
  end

  // A read is only issued when its word is guaranteed a FIFO slot on arrival.
  assign rden    = (state == S_READ) && (rd_left != '0) &&
                   ((in_flight + fifo_count) < CW'(FIFO_DEPTH));
  assign raddr   = raddr_cnt;
  assign push    = vld_sr[READ_LATENCY-1];
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last  = m_valid && (wr_left == (ADDR_WIDTH+1)'(1));
  assign busy    = (state != S_IDLE);
  assign done    = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      raddr_cnt <= '0;
      rd_left   <= '0;
      wr_left   <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= S_READ;
              raddr_cnt <= base_addr;
              rd_left   <= len;
              wr_left   <= len;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (rden) begin
            raddr_cnt <= raddr_cnt + 1'b1;
            rd_left   <= rd_left - 1'b1;
            if (rd_left == (ADDR_WIDTH+1)'(1)) state <= S_DRAIN;
          end
        end
        default: ;
      endcase
      if (pop && (wr_left != '0)) wr_left <= wr_left - 1'b1;
      if (pop && (wr_left == (ADDR_WIDTH+1)'(1))) begin
        state  <= S_IDLE;
        done_r <= 1'b1;
      end
    end
  end

  // Cleared on reset so data still returning from the BRAM afterwards is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | READ_LATENCY'(rden);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_dm_unloader.sv
// Directed bench for dm_unloader with a 2-cycle BRAM model and an output monitor.
module tb_dm_unloader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  len = '0;
  logic        busy, done, rden, m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [7:0]  raddr;
  logic [31:0] rdata = '0;
  logic [31:0] m_data;
  logic [31:0] p1 = '0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dm_unloader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rden(rden), .raddr(raddr), .rdata(rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always @(posedge clk) begin
    if (rden) p1 <= mem[raddr];
    rdata <= p1;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] data_q[$];
  bit          last_q[$];
  logic [7:0]  raddr_q[$];
  int          acc_cyc[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, rden_cnt = 0, mvalid_cnt = 0;
  int issued = 0, accepted = 0, credit_viol = 0, stable_viol = 0;
  bit stall_prev = 1'b0;
  logic [31:0] stall_dat = '0;
  int b_d, b_r, b_done, b_cv, b_sv, b_rc, b_mv;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rden) begin
        if (issued - accepted >= 4) credit_viol++;
        raddr_q.push_back(raddr);
        issued++;
        rden_cnt++;
      end
      if (stall_prev && (!m_valid || m_data !== stall_dat)) stable_viol++;
      stall_prev = m_valid && !m_ready;
      stall_dat  = m_data;
      if (m_valid) mvalid_cnt++;
      if (m_valid && m_ready) begin
        data_q.push_back(m_data);
        last_q.push_back(m_last);
        acc_cyc.push_back(cyc);
        accepted++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      issued     = accepted;
      stall_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic snap();
    b_d = data_q.size(); b_r = raddr_q.size(); b_done = done_cnt;
    b_cv = credit_viol; b_sv = stable_viol; b_rc = rden_cnt; b_mv = mvalid_cnt;
  endtask

  task automatic start_win(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk(tag, ok, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_win(input string tag, input int b, input int n);
    int nd = data_q.size() - b_d;
    int de = 0, le = 0;
    chk({tag, "_cnt"}, nd, n);
    for (int i = 0; i < n && i < nd; i++) begin
      if (data_q[b_d+i] !== mem[(b+i)%256]) de++;
      if (last_q[b_d+i] !== (i == n-1)) le++;
    end
    chk({tag, "_data"}, de, 0);
    chk({tag, "_last"}, le, 0);
  endtask

  initial begin
    int lat, ae, cerr;
    int seen [256];
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;

    #12;
    chk("reset_vals", {busy, done, rden, raddr, m_valid, m_last, m_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic window
    snap(); m_ready = 1'b1;
    start_win(8'h10, 9'd4);
    chk("t1_busy", busy, 1);
    lat = 0;
    while (!m_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("t1_first_valid_lat", lat, 3);
    wait_done("t1_done", 40);
    chk_win("t1", 'h10, 4);
    if (data_q.size() >= b_d + 4) begin
      chk("t1_consecutive", acc_cyc[b_d+3] - acc_cyc[b_d], 3);
      chk("t1_done_after_last", done_cyc - acc_cyc[b_d+3], 1);
    end else chk("t1_words_missing", data_q.size() - b_d, 4);
    chk("t1_busy_after", busy, 0);

    // backpressure
    snap();
    start_win(8'h40, 9'd8);
    for (int i = 0; i < 80; i++) begin
      m_ready = (i >= 4 && i < 14) ? 1'b0 : (i % 3 == 0);
      @(posedge clk); #1;
      if (done_cnt != b_done) break;
    end
    m_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t2_done_cnt", done_cnt - b_done, 1);
    chk_win("t2", 'h40, 8);
    chk("t2_credit", credit_viol - b_cv, 0);
    chk("t2_stable", stable_viol - b_sv, 0);

    // address wrap
    snap();
    start_win(8'hFE, 9'd4);
    wait_done("t3_done", 40);
    chk("t3_raddr_cnt", raddr_q.size() - b_r, 4);
    ae = 0;
    for (int i = 0; i < 4 && b_r + i < raddr_q.size(); i++)
      if (raddr_q[b_r+i] !== 8'((8'hFE + i) % 256)) ae++;
    chk("t3_raddr_seq", ae, 0);
    chk_win("t3", 'hFE, 4);

    // len = 0
    snap();
    start_win(8'h33, 9'd0);
    chk("t4_len0_done", done, 1);
    chk("t4_len0_busy", busy, 0);
    @(posedge clk); #1;
    chk("t4_len0_done_pulse", done, 0);
    repeat (6) @(posedge clk); #1;
    chk("t4_len0_rden", rden_cnt - b_rc, 0);
    chk("t4_len0_mvalid", mvalid_cnt - b_mv, 0);
    chk("t4_len0_done_cnt", done_cnt - b_done, 1);

    // len = 256
    snap();
    start_win(8'h80, 9'd256);
    wait_done("t4_full_done", 400);
    chk_win("t4_full", 'h80, 256);
    chk("t4_full_raddr_cnt", raddr_q.size() - b_r, 256);
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = b_r; i < raddr_q.size(); i++) seen[raddr_q[i]]++;
    cerr = 0;
    for (int i = 0; i < 256; i++) if (seen[i] != 1) cerr++;
    chk("t4_full_coverage", cerr, 0);
    if (data_q.size() >= b_d + 256) chk("t4_full_rate", acc_cyc[b_d+255] - acc_cyc[b_d], 255);
    else chk("t4_full_words_missing", data_q.size() - b_d, 256);

    // reset mid-window
    snap();
    start_win(8'h30, 9'd16);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (data_q.size() - b_d >= 5) break;
    end
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", {busy, done, rden, raddr, m_valid, m_last, m_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t5_no_stale_valid", m_valid, 0);
    snap();
    start_win(8'h00, 9'd2);
    wait_done("t5_done", 40);
    chk_win("t5", 0, 2);

    // start while busy
    snap();
    start_win(8'h50, 9'd6);
    @(posedge clk);
    start_win(8'h20, 9'd3);
    wait_done("t6_done", 60);
    repeat (10) @(posedge clk); #1;
    chk_win("t6", 'h50, 6);
    chk("t6_done_cnt", done_cnt - b_done, 1);
    chk("t6_raddr_cnt", raddr_q.size() - b_r, 6);
    chk("t6_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dm_unloader.md
Name: dm_unloader

Overview:
- Read-side drain engine for the PE data memory.
- On a start command it reads a contiguous address window out of the data BRAM, compensating for the fixed 2-cycle registered read latency.
- Streams the words to the array output over a valid/ready interface, with credit-based flow control so that no read word is ever dropped under backpressure.
- Sits between the data memory read port (rden / read address / doutb) and the PE-array result output.

Parameters:
- DATA_WIDTH, 32, width of one memory word (a complex pair of 16-bit values).
- ADDR_WIDTH, 8, data memory address width (256 entries).
- READ_LATENCY, 2, cycles from rden/raddr to valid rdata (BRAM in HIGH_PERFORMANCE mode).
- FIFO_DEPTH, 4, output buffer entries; must be >= READ_LATENCY+2 for full throughput.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; clears all state
- start  in  1  one-cycle command strobe; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first address of the window
- len  in  ADDR_WIDTH+1  number of words to read, 0..256
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word has been accepted (or immediately for len=0)
- rden  out  1  memory read enable (one read per cycle high)
- raddr  out  ADDR_WIDTH  memory read address, valid while rden=1
- rdata  in  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after the matching rden
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts the word when m_valid&m_ready
- m_data  out  DATA_WIDTH  output word
- m_last  out  1  high with the final word of the window

Behaviour:
- Reset values: busy=0, done=0, rden=0, raddr=0, m_valid=0, m_data=0, m_last=0. FSM=IDLE, FIFO empty, all counters 0.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - start=1 with len>0: latch base_addr into raddr_cnt and len into rd_left and wr_left, then go to READ.
  - start=1 with len=0: done pulses on the next cycle, busy stays 0, no reads are issued.
- READ:
  - rden is asserted in a cycle when rd_left>0 and (in_flight + fifo_count) < FIFO_DEPTH.
  - in_flight counts reads issued whose data has not yet been captured.
  - Each issue: raddr=raddr_cnt, raddr_cnt+1 (wraps 255->0, modulo 2^ADDR_WIDTH), rd_left-1.
  - When rd_left reaches 0, go to DRAIN.
- Capture:
  - A READ_LATENCY-deep valid shift register tracks rden.
  - rdata is pushed into the FIFO in the cycle its valid tap fires.
  - Overflow is impossible by the credit rule; an assertion checks this.
- Output:
  - m_valid = FIFO not empty; m_data = FIFO head (registered/show-ahead).
  - A pop occurs on m_valid&m_ready; wr_left decrements on each pop.
  - m_last = m_valid & (wr_left==1).
  - m_data and m_valid are held stable while m_ready=0.
- DRAIN:
  - The pop that takes wr_left 1->0 returns the FSM to IDLE.
  - done pulses the following cycle and busy drops in the same cycle as done.
- Throughput: with m_ready held high, one word per cycle after the initial latency.
  - First m_valid appears READ_LATENCY+1 cycles after start (1 cycle to latch, then READ_LATENCY).
- Simultaneous push and pop in the same cycle: fifo_count is unchanged; this is legal even when full.
- start while busy: ignored, with no effect on the current window.
- Reset mid-operation (rst_n low at any time): all state clears immediately. In-flight read data returning after release is discarded, because the valid shift register has been cleared.
- len=256: the full memory is read from base_addr, wrapping, and every address is read exactly once.

Test Plan:
1. Basic read: memory preloaded with mem[i]=i+0x1000; start base=0x10 len=4, m_ready=1 -> m_data 0x1010,0x1011,0x1012,0x1013 on consecutive cycles, m_last on the 4th word, done one cycle after, first m_valid 3 cycles after start.
2. Backpressure: base=0x40 len=8, m_ready toggling 1,0,0,1,... and held low 10 cycles -> all 8 words delivered in order, none lost or duplicated; rden never issued with in_flight+fifo_count>=4; m_data stable while stalled.
3. Wrap: base=0xFE len=4 -> raddr sequence 0xFE,0xFF,0x00,0x01; data matches those addresses.
4. Boundaries: len=0 -> done pulse next cycle, rden and m_valid never high. len=256 base=0x80 -> 256 words, each address read exactly once, m_last only on word 256.
5. Reset mid-window: len=16, assert rst_n low after 5 words are accepted -> all outputs at reset values asynchronously. After release, a new start base=0 len=2 returns only mem[0],mem[1], with no stale words.
6. Start while busy: a second start (base=0x20 len=3) during an active len=6 window -> ignored; exactly 6 words, one done pulse.
